// File: rtl/spio_spinnaker_link_pkt_arbiter.sv
// Round-robin arbiter feeding a single-slot 72-bit packet buffer; 1-cycle latency, ready gated by buffer space.
// Define SPIO_PKT_ARB_PARITY_CHECK_EN to drop and count granted packets with bad odd parity.
module spio_spinnaker_link_pkt_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = 2
) (
  input  logic                    CLK_IN,
  input  logic                    RESET_IN,
  input  logic [72*NUM_PORTS-1:0] PKT_DATA_IN,
  input  logic [NUM_PORTS-1:0]    PKT_VLD_IN,
  output logic [NUM_PORTS-1:0]    PKT_RDY_OUT,
  output logic [71:0]             PKT_DATA_OUT,
  output logic                    PKT_VLD_OUT,
  input  logic                    PKT_RDY_IN,
  output logic [PTR_W-1:0]        GNT_PORT_OUT,
  output logic [15:0]             DROP_CNT_OUT
);

  logic             can_acc;
  logic             found;
  logic [PTR_W-1:0] sel;
  logic [71:0]      sel_pkt;
  logic             acc;
  logic             good;

  // Scan starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(GNT_PORT_OUT) + k) % NUM_PORTS;
      if (!found && PKT_VLD_IN[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  assign can_acc = !PKT_VLD_OUT || PKT_RDY_IN;
  assign acc     = found && can_acc && !RESET_IN;
  assign sel_pkt = PKT_DATA_IN[72*int'(sel) +: 72];

  always_comb begin
    PKT_RDY_OUT = '0;
    if (acc) PKT_RDY_OUT[sel] = 1'b1;
  end

`ifdef SPIO_PKT_ARB_PARITY_CHECK_EN
  assign good = sel_pkt[1] ? (^sel_pkt) : (^sel_pkt[39:0]);

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      DROP_CNT_OUT <= '0;
    end else if (acc && !good && DROP_CNT_OUT != 16'hFFFF) begin
      DROP_CNT_OUT <= DROP_CNT_OUT + 16'd1;
    end
  end
`else
  assign good         = 1'b1;
  assign DROP_CNT_OUT = '0;
`endif

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      PKT_VLD_OUT  <= 1'b0;
      PKT_DATA_OUT <= '0;
      GNT_PORT_OUT <= PTR_W'(NUM_PORTS - 1);
    end else begin
      if (acc) GNT_PORT_OUT <= sel;
      // A dropped packet still consumes the grant but leaves the buffer alone.
      if (acc && good) begin
        PKT_DATA_OUT <= sel_pkt;
        PKT_VLD_OUT  <= 1'b1;
      end else if (PKT_RDY_IN) begin
        PKT_VLD_OUT  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spio_spinnaker_link_pkt_arbiter.sv
// Directed bench for the packet arbiter: reset, single source, fairness, backpressure, parity, async reset.
module tb_spio_spinnaker_link_pkt_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [287:0] data_in;
  logic [3:0]   vld_in;
  logic [3:0]   rdy_out;
  logic [71:0]  data_out;
  logic         vld_out;
  logic         rdy_in;
  logic [1:0]   gnt;
  logic [15:0]  drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spio_spinnaker_link_pkt_arbiter #(.NUM_PORTS(4), .PTR_W(2)) dut (
    .CLK_IN       (clk),
    .RESET_IN     (rst),
    .PKT_DATA_IN  (data_in),
    .PKT_VLD_IN   (vld_in),
    .PKT_RDY_OUT  (rdy_out),
    .PKT_DATA_OUT (data_out),
    .PKT_VLD_OUT  (vld_out),
    .PKT_RDY_IN   (rdy_in),
    .GNT_PORT_OUT (gnt),
    .DROP_CNT_OUT (drop_cnt)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Builds a packet with correct odd parity over the covered bits.
  function automatic logic [71:0] mk(input logic [31:0] key, input logic [31:0] pl, input logic has_pl);
    logic [71:0] p;
    p = {has_pl ? pl : 32'h0, key, 6'b0, has_pl, 1'b0};
    p[0] = has_pl ? ~(^p) : ~(^p[39:0]);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld_in = '0; rdy_in = 1'b0; data_in = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [71:0] pa, pb, pd, bad, good_p;
  int          idx [4];
  logic [3:0]  acc;
  int          e;

  initial begin
    rst = 1'b1; vld_in = 4'hF; rdy_in = 1'b1; data_in = '0;
    #2;
    chk("rst_vld", 72'(vld_out), 72'(0));
    chk("rst_data", data_out, 72'h0);
    chk("rst_gnt", 72'(gnt), 72'(3));
    chk("rst_drop", 72'(drop_cnt), 72'(0));
    chk("rst_rdy", 72'(rdy_out), 72'(0));
    do_reset();

    // single source on port 2
    pa = mk(32'h0000_0001, 32'h0, 1'b0);
    data_in[72*2 +: 72] = pa; vld_in = 4'b0100; rdy_in = 1'b1;
    #1 chk("single_rdy", 72'(rdy_out), 72'(4'b0100));
    tick();
    vld_in = '0;
    chk("single_data", data_out, pa);
    chk("single_vld", 72'(vld_out), 72'(1));
    chk("single_gnt", 72'(gnt), 72'(2));
    #1 chk("single_rdy_off", 72'(rdy_out), 72'(0));
    tick();
    chk("single_drain", 72'(vld_out), 72'(0));

    // fairness: all ports, 8 packets each
    do_reset();
    for (int p = 0; p < 4; p++) idx[p] = 0;
    rdy_in = 1'b1;
    for (int c = 0; c < 32; c++) begin
      for (int p = 0; p < 4; p++) begin
        vld_in[p] = (idx[p] < 8);
        data_in[72*p +: 72] = mk({24'h0, 4'(p), 4'(idx[p])}, 32'hA000_0000 + 32'(c), 1'b1);
      end
      e = c % 4;
      #1 chk("fair_rdy", 72'(rdy_out), 72'(4'b0001 << e));
      acc = rdy_out;
      tick();
      for (int p = 0; p < 4; p++) if (acc[p]) idx[p]++;
      chk("fair_data", data_out, mk({24'h0, 4'(e), 4'(c / 4)}, 32'hA000_0000 + 32'(c), 1'b1));
      chk("fair_vld", 72'(vld_out), 72'(1));
    end
    vld_in = '0;
    tick();
    chk("fair_done", 72'(vld_out), 72'(0));

    // backpressure with ports 1 and 3 waiting
    do_reset();
    pa = mk(32'h0000_00AA, 32'h0, 1'b0);
    pb = mk(32'h0000_00BB, 32'h1234_5678, 1'b1);
    pd = mk(32'h0000_00DD, 32'h0, 1'b0);
    data_in[0 +: 72] = pa; vld_in = 4'b0001; rdy_in = 1'b0;
    tick();
    vld_in = 4'b1010;
    data_in[72*1 +: 72] = pb; data_in[72*3 +: 72] = pd;
    for (int c = 0; c < 10; c++) begin
      #1 chk("bp_rdy", 72'(rdy_out), 72'(0));
      tick();
      chk("bp_data", data_out, pa);
      chk("bp_vld", 72'(vld_out), 72'(1));
    end
    rdy_in = 1'b1;
    #1 chk("bp_rel_rdy1", 72'(rdy_out), 72'(4'b0010));
    tick();
    vld_in = 4'b1000;
    chk("bp_data_b", data_out, pb);
    chk("bp_gnt1", 72'(gnt), 72'(1));
    #1 chk("bp_rel_rdy3", 72'(rdy_out), 72'(4'b1000));
    tick();
    vld_in = '0;
    chk("bp_data_d", data_out, pd);
    chk("bp_gnt3", 72'(gnt), 72'(3));
    tick();
    chk("bp_empty", 72'(vld_out), 72'(0));

    // parity: bad then good on port 0
    do_reset();
    good_p = mk(32'h0000_0042, 32'hDEAD_BEEF, 1'b1);
    bad = good_p ^ 72'h1;
    data_in[0 +: 72] = bad; vld_in = 4'b0001; rdy_in = 1'b1;
    #1 chk("par_bad_rdy", 72'(rdy_out), 72'(4'b0001));
    tick();
`ifdef SPIO_PKT_ARB_PARITY_CHECK_EN
    chk("par_bad_vld", 72'(vld_out), 72'(0));
    chk("par_drop1", 72'(drop_cnt), 72'(1));
`else
    chk("par_bad_fwd", data_out, bad);
    chk("par_drop0", 72'(drop_cnt), 72'(0));
`endif
    chk("par_bad_gnt", 72'(gnt), 72'(0));
    data_in[0 +: 72] = good_p;
    #1 chk("par_good_rdy", 72'(rdy_out), 72'(4'b0001));
    tick();
    vld_in = '0;
    chk("par_good_data", data_out, good_p);
    chk("par_good_vld", 72'(vld_out), 72'(1));
`ifdef SPIO_PKT_ARB_PARITY_CHECK_EN
    chk("par_drop_hold", 72'(drop_cnt), 72'(1));
`else
    chk("par_drop_hold", 72'(drop_cnt), 72'(0));
`endif

    // asynchronous reset with a held packet
    do_reset();
    pa = mk(32'h0000_0077, 32'h0, 1'b0);
    data_in[72*1 +: 72] = pa; vld_in = 4'b0010; rdy_in = 1'b0;
    tick();
    vld_in = '0;
    chk("ar_pre_vld", 72'(vld_out), 72'(1));
    #2 rst = 1'b1;
    #1;
    chk("ar_vld", 72'(vld_out), 72'(0));
    chk("ar_data", data_out, 72'h0);
    chk("ar_gnt", 72'(gnt), 72'(3));
    pb = mk(32'h0000_0100, 32'h0, 1'b0);
    pd = mk(32'h0000_0300, 32'h0, 1'b0);
    data_in[0 +: 72] = pb; data_in[72*3 +: 72] = pd; vld_in = 4'b1001;
    #1 chk("ar_rdy_in_rst", 72'(rdy_out), 72'(0));
    tick();
    rst = 1'b0;
    #1 chk("ar_first_rdy", 72'(rdy_out), 72'(4'b0001));
    tick();
    vld_in = '0;
    chk("ar_first_gnt", 72'(gnt), 72'(0));
    chk("ar_first_data", data_out, pb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spio_spinnaker_link_pkt_arbiter.md
# spio_spinnaker_link_pkt_arbiter

Round-robin arbiter that shares one `spio_spinnaker_link_sender` between several packet sources. It sits directly upstream of the sender's 72-bit packet interface. Each cycle it selects one requesting source and registers that source's packet into a single-slot output buffer. The buffer presents a standard valid/ready stream to the sender at one packet per cycle when the sender is ready.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesting sources, legal range 2..8.
- `PTR_W`, 2: width of the port index; must equal ceil(log2(`NUM_PORTS`)).

Ports:
- `CLK_IN`  in  1  single clock; all state changes on its rising edge.
- `RESET_IN`  in  1  asynchronous, active-high reset.
- `PKT_DATA_IN`  in  72*NUM_PORTS  packets; port i occupies bits [72*i +: 72]. Packet layout: hdr [7:0] (bit 1 = payload present, bit 0 = parity), key [39:8], payload [71:40].
- `PKT_VLD_IN`  in  NUM_PORTS  per-port valid.
- `PKT_RDY_OUT`  out  NUM_PORTS  per-port ready; one-hot or zero.
- `PKT_DATA_OUT`  out  72  buffered packet to the sender.
- `PKT_VLD_OUT`  out  1  buffer holds a packet.
- `PKT_RDY_IN`  in  1  sender ready.
- `GNT_PORT_OUT`  out  PTR_W  index of the most recently accepted port.
- `DROP_CNT_OUT`  out  16  count of packets dropped for bad parity.

## Operation
- Transfer rule: a transfer occurs on any interface when valid and ready are both high at a rising edge.
- Accept condition: `can_acc` = !`PKT_VLD_OUT` || `PKT_RDY_IN`. The buffer is empty, or it is being emptied in the same cycle.
- Grant selection: scan ports starting at `GNT_PORT_OUT`+1, wrapping modulo NUM_PORTS. The first port with `PKT_VLD_IN` high is granted.
- Ready generation: `PKT_RDY_OUT[g]` = `can_acc` for the granted port g; all other ports see 0. Ready depends combinationally on `PKT_VLD_IN` and `PKT_RDY_IN`. Ready never depends on a port's own data.
- On acceptance:
  - `GNT_PORT_OUT` is set to g.
  - The packet is loaded into the buffer and `PKT_VLD_OUT` is set.
- If the buffer empties (transfer out) and no port is accepted in the same cycle, `PKT_VLD_OUT` clears.
- `PKT_DATA_OUT` is held stable while `PKT_VLD_OUT` && !`PKT_RDY_IN`. Once `PKT_VLD_OUT` is asserted it never deasserts without a transfer.
- No request present: `PKT_RDY_OUT` is all zero and `GNT_PORT_OUT` is unchanged.
- Packets leave in acceptance order; a single port's packets are never reordered.

## Timing
- Reset values:
  - `PKT_VLD_OUT`=0 and `PKT_DATA_OUT`=0.
  - `GNT_PORT_OUT`=NUM_PORTS-1, so port 0 wins the first arbitration.
  - `DROP_CNT_OUT`=0.
  - `PKT_RDY_OUT` is 0 while `RESET_IN` is high.
- Latency: a packet accepted at edge n appears on `PKT_DATA_OUT` with `PKT_VLD_OUT`=1 after edge n. One cycle from input transfer to output valid.
- Throughput: one packet per cycle when `PKT_RDY_IN` is held high. With all ports requesting continuously, the grant order is 0,1,2,3,0,… and no port waits more than NUM_PORTS-1 grants.
- Buffer full and `PKT_RDY_IN`=0: all `PKT_RDY_OUT` are 0. Upstream packets wait; `PKT_VLD_IN` must stay high with stable data until accepted.
- Buffer full and `PKT_RDY_IN`=1: simultaneous output transfer and input accept; the buffer remains full with the new packet.
- Pointer wrap: after a grant to port NUM_PORTS-1, the scan starts at port 0.
- Reset mid-operation: a buffered packet is discarded and not delivered. Outputs take their reset values immediately (asynchronously).

## Configuration
- Macro: `SPIO_PKT_ARB_PARITY_CHECK_EN`.
- Defined:
  - The granted packet is checked for odd parity. The XOR of bits [39:0] must be 1 when hdr bit 1 = 0; the XOR of bits [71:0] must be 1 when hdr bit 1 = 1.
  - A failing packet is still accepted (`PKT_RDY_OUT` pulses) and `GNT_PORT_OUT` still advances.
  - A failing packet is not loaded into the buffer, and `DROP_CNT_OUT` increments, saturating at 16'hFFFF.
  - If the buffer empties in the same cycle, `PKT_VLD_OUT` clears.
- Undefined: no check is performed, every accepted packet is forwarded, and `DROP_CNT_OUT` is constant 0.

## Test plan
- Single source: port 2 sends key 32'h0000_0001, no payload, correct parity, with `PKT_RDY_IN`=1. Required: `PKT_RDY_OUT`=4'b0100 for 1 cycle; the identical 72 bits appear on `PKT_DATA_OUT` with `PKT_VLD_OUT`=1 the next cycle; `GNT_PORT_OUT`=2.
- Fairness: all 4 ports request continuously for 8 packets each, with `PKT_RDY_IN`=1. Required: output port order 0,1,2,3 repeated; 32 packets in 32 consecutive cycles; no per-port reordering.
- Backpressure: buffer full, `PKT_RDY_IN`=0 for 10 cycles with ports 1 and 3 requesting. Required: `PKT_RDY_OUT`=0 and `PKT_DATA_OUT` stable throughout. Then `PKT_RDY_IN`=1: port 1 is accepted on the same edge the held packet leaves, and port 3 the following cycle.
- Parity (macro defined): port 0 sends a payload packet with the hdr bit 0 parity bit inverted, followed by a good packet. Required: the first is accepted but not forwarded; `DROP_CNT_OUT`=1; the second is forwarded the next cycle. With the macro undefined, both are forwarded and `DROP_CNT_OUT`=0.
- Reset mid-operation: assert `RESET_IN` between clock edges while `PKT_VLD_OUT`=1 and `PKT_RDY_IN`=0. Required: `PKT_VLD_OUT`=0 immediately (asynchronously); after release, port 0 wins the first grant even if ports 0 and 3 both request.
